deserializer: RTL and testbench
===============================

// Module: deserializer
// PURPOSE
// - Receive side of the cache line <-> memory word transfer.
// - Collects WORDS 32-bit words from the memory side into one 256-bit cache line and presents it to the cache fill path.
// - Word 0 arrives first and lands in line bits [31:0]; word 7 lands in [255:224].
// - The line is held until the fill path accepts it.
// PARAMETERS
// - WORD_W  32  width of one transferred word
// - WORDS   8   words per cache line; LINE_W = WORD_W*WORDS (256)
// PORTS
// - clk        in   1       single clock, rising edge
// - rst_n      in   1       asynchronous, active-low reset
// - abort      in   1       synchronous; discards a partial or complete line
// - in_valid   in   1       data_in carries a valid word
// - in_ready   out  1       block can accept a word this cycle
// - data_in    in   WORD_W  incoming word
// - out_valid  out  1       data_out holds a complete line
// - out_ready  in   1       fill path takes the line this cycle
// - data_out   out  LINE_W  assembled line, word i at [i*WORD_W +: WORD_W]
// - word_cnt   out  3       words captured so far in the current line (0..WORDS-1)
// BEHAVIOUR
// - Clock and reset: one clock `clk`; reset `rst_n` is asynchronous, active-low.
// - Reset values: state=COLLECT, word_cnt=0, out_valid=0, data_out=0.
//   in_ready is 1 on the first edge after reset deassertion.
// - FSM states: COLLECT, FULL.
//   in_ready = (state==COLLECT) && !abort.
//   out_valid = (state==FULL), registered.
// - Word accept (COLLECT, in_valid && in_ready):
//   - Write data_in into lane word_cnt; other lanes hold.
//   - If word_cnt<WORDS-1, increment word_cnt.
//   - If word_cnt==WORDS-1, set word_cnt=0 and go to FULL.
// - Latency: out_valid rises on the edge that captures word WORDS-1.
//   It is visible the cycle after that word was presented.
//   Minimum is WORDS cycles from the first accept.
// - FULL state:
//   - in_ready=0; in_valid is ignored and no lane changes.
//   - data_out is stable while out_valid=1 && !out_ready.
//   - out_valid && out_ready: go to COLLECT on the next edge.
//   - There is no same-cycle bypass: a word is accepted at the earliest on the cycle after the handshake.
// - Gaps: in_valid=0 in COLLECT holds word_cnt and all lanes. Any gap length is legal.
// - abort (highest priority, any state):
//   - Next edge: state=COLLECT, word_cnt=0, out_valid=0.
//   - data_out lanes are not cleared.
//   - A word presented in the abort cycle is dropped.
// - Reset mid-line: behaves as abort, and data_out is also cleared to 0.
// - Stale lanes: data_out is defined only while out_valid=1. All lanes are rewritten before the next out_valid.
// - word_cnt arithmetic: 3-bit, wraps only through the explicit WORDS-1 -> 0 rule, never by overflow.
// - Protocol: the line order matches the serializer in the same block directory.
//   serializer(line) -> deserializer reproduces the line bit-exactly.
// STRUCTURE
// - cache_pkg holds:
//   - WORD_W, WORDS_PER_LINE, LINE_W constants
//   - typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_words_t
//   - typedef enum logic {COLLECT, FULL} deser_state_t
// - Single module; no sub-module. Contents:
//   - state register
//   - word_cnt counter
//   - lane register array with per-lane write enable (decode of word_cnt & accept)
// TESTING
// 1. Back-to-back fill: in_valid=1 with words 0x11111111..0x88888888, out_ready=1.
//    -> out_valid on cycle 8 after first accept; data_out=0x88888888_..._11111111; one-cycle pulse; in_ready=0 for exactly that cycle.
// 2. Backpressure: complete a line, hold out_ready=0 for 5 cycles while driving in_valid=1 with 0xDEADBEEF.
//    -> data_out unchanged, in_ready=0 throughout, word_cnt=0; release -> next line starts at lane 0.
// 3. Gapped input: words at random intervals with in_valid low 0-4 cycles between them.
//    -> word_cnt steps 0..7 only on accepts; line correct.
// 4. Abort after 3 words, then 8 fresh words 0xA0..0xA7.
//    -> word_cnt=0 after abort; out_valid only after all 8 new words; lanes 0-7 = A0..A7.
// 5. Async reset pulse mid-line (word_cnt=5).
//    -> out_valid=0, word_cnt=0, data_out=0 immediately, without waiting for clk.
//    -> in_ready=1 after release.
// 6. Loopback: serializer driven with random 256-bit lines, output fed to data_in.
//    -> 100 lines reassembled bit-exact.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared constants and types for the cache line <-> memory word transfer path.
package cache_pkg;

  localparam int WORD_W         = 32;
  localparam int WORDS_PER_LINE = 8;
  localparam int LINE_W         = WORD_W * WORDS_PER_LINE;
  localparam int CNT_W          = 3;

  typedef logic [WORDS_PER_LINE-1:0][WORD_W-1:0] line_words_t;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } deser_state_t;

endpackage

// File: rtl/deserializer.sv
// Receive side of the line transfer: gathers WORDS_PER_LINE words, lowest lane
// first, into one cache line and holds it until the fill path takes it.
module deserializer
  import cache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] data_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINE_W-1:0] data_out,
  output logic [CNT_W-1:0]  word_cnt
);

  localparam int               WORDS = WORDS_PER_LINE;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WORDS - 1);

  deser_state_t        state;
  line_words_t         lanes;
  logic                accept;
  logic [WORDS-1:0]    lane_we;

  // Abort blocks acceptance in the same cycle so a word presented with it is dropped.
  assign in_ready  = (state == COLLECT) && !abort;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == FULL);
  assign data_out  = lanes;

  // Control: collect/full sequencing and the word counter; abort overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= COLLECT;
      word_cnt <= '0;
    end else if (abort) begin
      state    <= COLLECT;
      word_cnt <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (accept) begin
            if (word_cnt == LAST) begin
              word_cnt <= '0;
              state    <= FULL;
            end else begin
              word_cnt <= word_cnt + CNT_W'(1);
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            state <= COLLECT;
          end
        end
        default: begin
          state    <= COLLECT;
          word_cnt <= '0;
        end
      endcase
    end
  end

  // Decode the current lane so only the addressed word register loads.
  always_comb begin
    lane_we = '0;
    if (accept) begin
      lane_we[word_cnt] = 1'b1;
    end
  end

  // Lane storage: each lane loads only on its own enable; abort leaves contents alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lanes <= '0;
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (lane_we[i]) begin
          lanes[i] <= data_in;
        end
      end
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for the line deserializer: stimulus feeds a word-level model
// that queues expected lines; a monitor compares every presented line.
module tb_deserializer;
  import cache_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              abort;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [LINE_W-1:0] data_out;
  logic [CNT_W-1:0]  word_cnt;

  int checks = 0;
  int errors = 0;

  logic [LINE_W-1:0] exp_q[$];
  logic [WORD_W-1:0] cur_q[$];
  bit                lb_mode    = 1'b0;
  int                ready_mode = 1;

  always #5 clk = ~clk;

  deserializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .word_cnt  (word_cnt)
  );

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Fill path: 0 = stall, 1 = always ready, otherwise random per cycle.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: handshake rule every cycle, line contents whenever a line is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("in_ready_rule", in_ready, !out_valid && !abort);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_line actual=%0h required=no_line", data_out);
          end else begin
            check("line", data_out, exp_q[0]);
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // Model: a line is the eight accepted words, word 0 in the low bits.
  task automatic model_accept(input logic [WORD_W-1:0] w);
    logic [LINE_W-1:0] l;
    cur_q.push_back(w);
    if (cur_q.size() == WORDS_PER_LINE) begin
      for (int i = 0; i < WORDS_PER_LINE; i++) l[i*WORD_W +: WORD_W] = cur_q[i];
      if (!lb_mode) exp_q.push_back(l);
      cur_q.delete();
    end
  endtask

  task automatic send_word(input logic [WORD_W-1:0] w);
    int n;
    data_in  = w;
    in_valid = 1'b1;
    n        = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual=0 required=1");
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model_accept(w);
    check("word_cnt", word_cnt, cur_q.size());
    check("out_valid_after_accept", out_valid, cur_q.size() == 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [LINE_W-1:0] line;
    int                n;
    rst_n    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    data_in  = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_data_out", data_out, 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_reset", in_ready, 1);

    // 1. Back-to-back fill with a one-cycle output pulse
    ready_mode = 1;
    for (int i = 0; i < 8; i++) send_word(32'h1111_1111 * (i + 1));
    @(posedge clk);
    #1;
    check("pulse_out_valid_low", out_valid, 0);
    check("pulse_in_ready_back", in_ready, 1);

    // 2. Backpressure while the input keeps offering a word
    ready_mode = 0;
    for (int i = 0; i < 8; i++) send_word($urandom);
    in_valid = 1'b1;
    data_in  = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_word_cnt", word_cnt, 0);
      check("bp_out_valid", out_valid, 1);
    end
    ready_mode = 1;
    send_word(32'hDEAD_BEEF);
    for (int i = 0; i < 7; i++) send_word($urandom);

    // 3. Gapped input with a random fill path
    ready_mode = 2;
    for (int i = 0; i < 16; i++) begin
      idle($urandom_range(0, 4));
      send_word($urandom);
    end

    // 4. Abort after three words, with a word offered in the abort cycle
    ready_mode = 1;
    for (int i = 0; i < 3; i++) send_word($urandom);
    abort    = 1'b1;
    in_valid = 1'b1;
    data_in  = 32'h0BAD_F00D;
    #1;
    check("abort_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    cur_q.delete();
    check("abort_word_cnt", word_cnt, 0);
    check("abort_out_valid", out_valid, 0);
    for (int i = 0; i < 8; i++) send_word(32'hA0 + i);

    // 5. Asynchronous reset at word_cnt=5
    for (int i = 0; i < 5; i++) send_word($urandom);
    #2 rst_n = 1'b0;
    #1;
    check("areset_out_valid", out_valid, 0);
    check("areset_word_cnt", word_cnt, 0);
    check("areset_data_out", data_out, 0);
    cur_q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("areset_in_ready", in_ready, 1);

    // 6. Loopback of random lines through a behavioural serializer
    lb_mode    = 1'b1;
    ready_mode = 2;
    for (int k = 0; k < 100; k++) begin
      for (int i = 0; i < WORDS_PER_LINE; i++) line[i*WORD_W +: WORD_W] = $urandom;
      exp_q.push_back(line);
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        idle($urandom_range(0, 2));
        send_word(line[i*WORD_W +: WORD_W]);
      end
    end

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
